// File: rtl/keccak_block_loader.sv
// Purpose : packs a 32-bit message word stream into two-word Keccak state-register
//           writes, zero-fills the tail of a partial rate block and kicks the permutation.
// Latency : a write appears one cycle after its second word (or final odd word) is accepted;
//           perm_start_o comes one cycle after the block's last write; done_o comes one
//           cycle after the final perm_done_i.
// Backpress: in_ready_o is high only while filling; words are held off during zero-fill,
//           permutation and completion.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               begin a message (only honoured when idle)
//   in_valid_i/in_ready_o word handshake; in_data_i word, in_last_i marks final word
//   reg_en_o/reg_index_o  state-register two-lane write: lanes index and index+1
//   reg_data0_o/1_o       data for lane index / index+1
//   perm_start_o          one-cycle permutation kick; perm_done_i completion pulse
//   busy_o, done_o        status; block_cnt_o permutations issued since start_i (saturating)

module keccak_block_loader #(
   parameter int RATE_WORDS = 34,   // even, 2..50
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      in_data_i,
   input  logic             in_last_i,
   output logic             reg_en_o,
   output logic [5:0]       reg_index_o,
   output logic [31:0]      reg_data0_o,
   output logic [31:0]      reg_data1_o,
   output logic             perm_start_o,
   input  logic             perm_done_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] block_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_FLUSH,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   // Index of the last lane pair inside the rate portion.
   localparam logic [5:0] LAST_IDX = 6'(RATE_WORDS - 2);

   state_t             state_q, state_d;
   logic [5:0]         idx_q, idx_d;
   logic [31:0]        hold_q, hold_d;
   logic               phase_q, phase_d;
   logic               last_q, last_d;
   logic               reg_en_q, reg_en_d;
   logic [5:0]         reg_index_q, reg_index_d;
   logic [31:0]        reg_data0_q, reg_data0_d;
   logic [31:0]        reg_data1_q, reg_data1_d;
   logic               perm_start_q, perm_start_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   block_cnt_q, block_cnt_d;

   logic               accept;

   assign in_ready_o   = (state_q == S_FILL);
   assign busy_o       = (state_q != S_IDLE);
   assign accept       = in_valid_i && in_ready_o;

   assign reg_en_o     = reg_en_q;
   assign reg_index_o  = reg_index_q;
   assign reg_data0_o  = reg_data0_q;
   assign reg_data1_o  = reg_data1_q;
   assign perm_start_o = perm_start_q;
   assign done_o       = done_q;
   assign block_cnt_o  = block_cnt_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      hold_d       = hold_q;
      phase_d      = phase_q;
      last_d       = last_q;
      reg_en_d     = 1'b0;
      reg_index_d  = reg_index_q;
      reg_data0_d  = reg_data0_q;
      reg_data1_d  = reg_data1_q;
      perm_start_d = 1'b0;
      done_d       = 1'b0;
      block_cnt_d  = block_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d     = S_FILL;
               idx_d       = '0;
               phase_d     = 1'b0;
               last_d      = 1'b0;
               block_cnt_d = '0;
            end
         end

         S_FILL: begin
            if (accept) begin
               if (!phase_q && !in_last_i) begin
                  // First word of a pair: park it until its partner arrives.
                  hold_d  = in_data_i;
                  phase_d = 1'b1;
               end else begin
                  // Complete pair, or a lone final word padded with zero.
                  reg_en_d    = 1'b1;
                  reg_index_d = idx_q;
                  reg_data0_d = phase_q ? hold_q : in_data_i;
                  reg_data1_d = phase_q ? in_data_i : 32'h0;
                  idx_d       = idx_q + 6'd2;
                  phase_d     = 1'b0;
                  last_d      = last_q | in_last_i;
                  if (idx_q == LAST_IDX) begin
                     state_d = S_START;
                  end else if (in_last_i) begin
                     state_d = S_FLUSH;
                  end
               end
            end
         end

         S_FLUSH: begin
            reg_en_d    = 1'b1;
            reg_index_d = idx_q;
            reg_data0_d = 32'h0;
            reg_data1_d = 32'h0;
            idx_d       = idx_q + 6'd2;
            if (idx_q == LAST_IDX) begin
               state_d = S_START;
            end
         end

         // The block's final write is visible on the outputs during this cycle.
         S_START: begin
            state_d      = S_WAIT;
            perm_start_d = 1'b1;
            if (block_cnt_q != '1) begin
               block_cnt_d = block_cnt_q + 1'b1;
            end
         end

         // perm_start_q is high exactly on the first WAIT cycle, so it doubles as
         // the mask that ignores a done pulse coincident with the kick.
         S_WAIT: begin
            if (perm_done_i && !perm_start_q) begin
               if (last_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FILL;
                  idx_d   = '0;
                  phase_d = 1'b0;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         hold_q       <= '0;
         phase_q      <= 1'b0;
         last_q       <= 1'b0;
         reg_en_q     <= 1'b0;
         reg_index_q  <= '0;
         reg_data0_q  <= '0;
         reg_data1_q  <= '0;
         perm_start_q <= 1'b0;
         done_q       <= 1'b0;
         block_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         hold_q       <= hold_d;
         phase_q      <= phase_d;
         last_q       <= last_d;
         reg_en_q     <= reg_en_d;
         reg_index_q  <= reg_index_d;
         reg_data0_q  <= reg_data0_d;
         reg_data1_q  <= reg_data1_d;
         perm_start_q <= perm_start_d;
         done_q       <= done_d;
         block_cnt_q  <= block_cnt_d;
      end
   end

endmodule

// File: tb/tb_keccak_block_loader.sv
// Purpose : directed bench for keccak_block_loader (RATE_WORDS = 34) with a message-level
//           reference model: expected lane writes are the message split into rate blocks,
//           zero-padded, taken two words at a time.
// Latency : outputs sampled on the falling edge; inputs driven just after the rising edge.
// Backpress: the word driver holds each word until the DUT accepts it.

module tb_keccak_block_loader;

   localparam int RATE  = 34;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_i;
   logic             start_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [31:0]      in_data_i;
   logic             in_last_i;
   logic             reg_en_o;
   logic [5:0]       reg_index_o;
   logic [31:0]      reg_data0_o;
   logic [31:0]      reg_data1_o;
   logic             perm_start_o;
   logic             perm_done_i;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] block_cnt_o;

   keccak_block_loader #(.RATE_WORDS(RATE), .CNT_W(CNT_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_data_i    (in_data_i),
      .in_last_i    (in_last_i),
      .reg_en_o     (reg_en_o),
      .reg_index_o  (reg_index_o),
      .reg_data0_o  (reg_data0_o),
      .reg_data1_o  (reg_data1_o),
      .perm_start_o (perm_start_o),
      .perm_done_i  (perm_done_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .block_cnt_o  (block_cnt_o)
   );

   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] d0;
      logic [31:0] d1;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         wr_log[$];
   int          wr_cyc[$];
   logic [31:0] msg [0:127];

   int vec_cnt     = 0;
   int err_cnt     = 0;
   int cyc         = 0;
   int perm_cnt    = 0;
   int done_cnt    = 0;
   int last_pd_cyc = -100;
   int perm_delay  = 3;
   bit glitch_mode = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input string what);
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Observer: every write is checked against the model queue and logged.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (reg_en_o) begin
            wr_log.push_back({reg_index_o, reg_data0_o, reg_data1_o});
            wr_cyc.push_back(cyc);
            check("lane_range", {127'b0, (int'(reg_index_o) < RATE) && !reg_index_o[0]}, 128'd1);
            if (exp_q.size() == 0) begin
               fail("unexpected_write", $sformatf("idx=%0d d0=%0h d1=%0h", reg_index_o, reg_data0_o, reg_data1_o));
            end else begin
               check("write", {reg_index_o, reg_data0_o, reg_data1_o}, exp_q.pop_front());
            end
         end
         if (perm_start_o) perm_cnt++;
         if (done_o) begin
            done_cnt++;
            check("done_latency", cyc - last_pd_cyc, 1);
         end
      end
   end

   // Permutation core stand-in: answers each kick after perm_delay cycles
   // (perm_delay = 0 means never). glitch_mode adds pulses that must be ignored:
   // one while filling and one on the first WAIT cycle.
   initial begin
      int  pd_cnt;
      bit  fill_glitched;
      pd_cnt        = 0;
      fill_glitched = 0;
      perm_done_i   = 1'b0;
      forever begin
         @(negedge clk);
         perm_done_i = 1'b0;
         if (!glitch_mode) fill_glitched = 0;
         if (rst_i) begin
            pd_cnt = 0;
         end else if (glitch_mode && in_ready_o && !fill_glitched) begin
            perm_done_i   = 1'b1;
            fill_glitched = 1;
         end else if (perm_start_o) begin
            pd_cnt = perm_delay;
            if (glitch_mode) perm_done_i = 1'b1;
         end else if (pd_cnt > 0) begin
            pd_cnt--;
            if (pd_cnt == 0) begin
               perm_done_i = 1'b1;
               last_pd_cyc = cyc;
            end
         end
      end
   end

   // Model: message split into rate blocks, tail zero-padded, written pairwise.
   task automatic build_exp(input int len);
      int nblk;
      exp_q.delete();
      nblk = (len + RATE - 1) / RATE;
      for (int b = 0; b < nblk; b++) begin
         for (int i = 0; i < RATE / 2; i++) begin
            wr_t e;
            int  j;
            j     = b * RATE + 2 * i;
            e.idx = 6'(2 * i);
            e.d0  = (j < len)     ? msg[j]     : 32'h0;
            e.d1  = (j + 1 < len) ? msg[j + 1] : 32'h0;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic push_word(input logic [31:0] d, input bit last);
      bit acc;
      acc        = 0;
      in_valid_i = 1'b1;
      in_data_i  = d;
      in_last_i  = last;
      for (int t = 0; t < 500 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready_o;
         @(posedge clk);
         #1;
      end
      if (!acc) fail("push_timeout", $sformatf("word %0h never accepted", d));
   endtask

   task automatic do_start();
      @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
   endtask

   task automatic check_idle_outputs(input string name);
      check(name, {reg_en_o, reg_index_o, reg_data0_o, reg_data1_o, perm_start_o,
                   done_o, block_cnt_o, in_ready_o, busy_o}, 128'd0);
   endtask

   // Runs one message of len words from msg[], expecting exp_blocks permutations.
   task automatic run_msg(input int len, input int exp_blocks, input bit poke_start,
                          output int wb);
      int  pb, db;
      bit  seen;
      build_exp(len);
      wb = wr_log.size();
      pb = perm_cnt;
      db = done_cnt;
      do_start();
      for (int i = 0; i < len; i++) push_word(msg[i], i == len - 1);
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      if (poke_start) begin
         start_i = 1'b1;
         @(posedge clk);
         #1 start_i = 1'b0;
      end
      seen = 0;
      for (int t = 0; t < 2000 && !seen; t++) begin
         @(negedge clk);
         seen = (done_cnt > db);
      end
      if (!seen) fail("done_timeout", "done_o never pulsed");
      @(negedge clk);
      check("busy_after_done", {127'b0, busy_o}, 128'd0);
      check("done_count", done_cnt - db, 1);
      check("perm_count", perm_cnt - pb, exp_blocks);
      check("block_cnt", block_cnt_o, exp_blocks);
      check("writes_left", exp_q.size(), 0);
      check("write_count", wr_log.size() - wb, exp_blocks * RATE / 2);
   endtask

   initial begin
      int wb;
      bit seen;
      int pb;
      rst_i      = 1'b1;
      start_i    = 1'b0;
      in_valid_i = 1'b0;
      in_data_i  = 32'h0;
      in_last_i  = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_outputs");
      rst_i = 1'b0;

      // Idle with no start: everything stays quiet.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_idle_outputs("idle_outputs");
      end

      // Exactly one full block: no flush, one permutation.
      for (int i = 0; i < 34; i++) msg[i] = 32'(i + 1);
      run_msg(34, 1, 0, wb);
      check("blk_first_pair", wr_log[wb], {6'd0, 32'h1, 32'h2});
      check("blk_last_pair", wr_log[wb + 16], {6'd32, 32'h21, 32'h22});
      for (int i = 0; i < 16; i++)
         check("stream_spacing", wr_cyc[wb + i + 1] - wr_cyc[wb + i], 2);

      // Short message A, B, C with a start_i poke while busy.
      msg[0] = 32'hA0A0_0001;
      msg[1] = 32'hB0B0_0002;
      msg[2] = 32'hC0C0_0003;
      run_msg(3, 1, 1, wb);
      check("abc_pair", wr_log[wb], {6'd0, 32'hA0A0_0001, 32'hB0B0_0002});
      check("abc_odd", wr_log[wb + 1], {6'd2, 32'hC0C0_0003, 32'h0});
      check("abc_flush_first", wr_log[wb + 2], {6'd4, 32'h0, 32'h0});
      check("abc_flush_last", wr_log[wb + 16], {6'd32, 32'h0, 32'h0});
      for (int i = 1; i < 16; i++)
         check("flush_spacing", wr_cyc[wb + i + 1] - wr_cyc[wb + i], 1);

      // 35 words: full block then a single-word block padded with zeros.
      for (int i = 0; i < 35; i++) msg[i] = 32'(i + 1);
      run_msg(35, 2, 0, wb);
      check("w35_last_of_blk1", wr_log[wb + 16], {6'd32, 32'h21, 32'h22});
      check("w35_odd", wr_log[wb + 17], {6'd0, 32'h23, 32'h0});
      check("w35_flush_last", wr_log[wb + 33], {6'd32, 32'h0, 32'h0});

      // Spurious perm_done_i during FILL and on the first WAIT cycle.
      msg[0] = 32'h1111_1111;
      msg[1] = 32'h2222_2222;
      msg[2] = 32'h3333_3333;
      msg[3] = 32'h4444_4444;
      glitch_mode = 1;
      run_msg(4, 1, 0, wb);
      glitch_mode = 0;
      check("glitch_pair1", wr_log[wb + 1], {6'd2, 32'h3333_3333, 32'h4444_4444});

      // Asynchronous reset while waiting on the permutation mid-message.
      for (int i = 0; i < 34; i++) msg[i] = 32'(i + 1);
      perm_delay = 0;
      build_exp(34);
      pb = perm_cnt;
      do_start();
      for (int i = 0; i < 34; i++) push_word(msg[i], 1'b0);
      in_valid_i = 1'b0;
      seen = 0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(negedge clk);
         seen = (perm_cnt > pb);
      end
      if (!seen) fail("wait_timeout", "perm_start_o never pulsed before reset test");
      repeat (2) @(negedge clk);
      check("busy_in_wait", {127'b0, busy_o}, 128'd1);
      #2 rst_i = 1'b1;
      #1;
      check_idle_outputs("async_reset_outputs");
      check("writes_before_reset", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_idle_outputs("post_reset_idle");
      end
      perm_delay = 3;
      msg[0] = 32'h5555_0000;
      msg[1] = 32'h6666_0000;
      run_msg(2, 1, 0, wb);
      check("restart_pair", wr_log[wb], {6'd0, 32'h5555_0000, 32'h6666_0000});
      check("restart_flush", wr_log[wb + 1], {6'd2, 32'h0, 32'h0});

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
